// File: rtl/svc_gfx_fade_stage.sv
// Per-pixel fade stage: fades {age,pixel} framebuffer words for display and emits aged write-back.
// Optional write-back stream enabled by defining SVC_GFX_FADE_WB_EN.
module svc_gfx_fade_stage #(
    parameter int NUM_CHANNELS = 3,
    parameter int COLOR_WIDTH  = 4,
    parameter int PIXEL_WIDTH  = NUM_CHANNELS * COLOR_WIDTH,
    parameter int AGE_BITS     = 4,
    parameter int PERIOD_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [PERIOD_WIDTH-1:0] fade_period,
    input  logic                    fade_mode,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [AGE_BITS-1:0]     s_age,
    input  logic [PIXEL_WIDTH-1:0]  s_pixel,
    input  logic                    s_frame_end,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [PIXEL_WIDTH-1:0]  m_pixel,
    output logic                    m_frame_end,
    output logic                    m_wb_valid,
    input  logic                    m_wb_ready,
    output logic [AGE_BITS-1:0]     m_wb_age,
    output logic [PIXEL_WIDTH-1:0]  m_wb_pixel,
    output logic                    age_tick
);

    localparam int CMP_W = (AGE_BITS > COLOR_WIDTH) ? AGE_BITS : COLOR_WIDTH;
    localparam logic [AGE_BITS-1:0] MAX_AGE = '1;

    // Any age >= 2**COLOR_WIDTH is also >= every channel value, so one compare saturates both cases.
    function automatic logic [COLOR_WIDTH-1:0] fade_chan(
        input logic [COLOR_WIDTH-1:0] c,
        input logic [AGE_BITS-1:0]    a,
        input logic                   mode
    );
        logic [CMP_W-1:0] a_ext;
        logic [CMP_W-1:0] c_ext;
        logic [CMP_W-1:0] diff;
        a_ext = CMP_W'(a);
        c_ext = CMP_W'(c);
        diff  = c_ext - a_ext;
        if (a == MAX_AGE)
            return '0;
        if (!mode) begin
            if (a_ext >= CMP_W'(COLOR_WIDTH))
                return '0;
            return c >> a;
        end
        if (a_ext >= c_ext)
            return '0;
        return diff[COLOR_WIDTH-1:0];
    endfunction

    logic [PIXEL_WIDTH-1:0]  w_faded;
    logic [AGE_BITS-1:0]     w_aged;
    logic                    w_accept;
    logic                    w_s_ready;
    logic                    w_frame_last;

    logic                    r_m_valid;
    logic [PIXEL_WIDTH-1:0]  r_pixel;
    logic                    r_frame_end;
    logic [PERIOD_WIDTH-1:0] r_frame_cnt;
    logic                    r_age_tick;

    always_comb begin
        w_faded = '0;
        for (int unsigned i = 0; i < NUM_CHANNELS; i++)
            w_faded[i*COLOR_WIDTH +: COLOR_WIDTH] =
                fade_chan(s_pixel[i*COLOR_WIDTH +: COLOR_WIDTH], s_age, fade_mode);
    end

    assign w_aged       = (r_age_tick && s_age != MAX_AGE) ? s_age + AGE_BITS'(1) : s_age;
    assign w_accept     = s_valid && w_s_ready;
    assign w_frame_last = r_frame_cnt >= (fade_period - PERIOD_WIDTH'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_valid   <= 1'b0;
            r_pixel     <= '0;
            r_frame_end <= 1'b0;
        end else if (w_accept) begin
            r_m_valid   <= 1'b1;
            r_pixel     <= w_faded;
            r_frame_end <= s_frame_end;
        end else if (m_ready) begin
            r_m_valid   <= 1'b0;
        end
    end

`ifdef SVC_GFX_FADE_WB_EN
    logic                   r_wb_valid;
    logic [AGE_BITS-1:0]    r_wb_age;
    logic [PIXEL_WIDTH-1:0] r_wb_pixel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_valid <= 1'b0;
            r_wb_age   <= '0;
            r_wb_pixel <= '0;
        end else if (w_accept) begin
            r_wb_valid <= 1'b1;
            r_wb_age   <= w_aged;
            r_wb_pixel <= s_pixel;
        end else if (m_wb_ready) begin
            r_wb_valid <= 1'b0;
        end
    end

    // Slot reusable when every still-valid output is consumed this cycle.
    assign w_s_ready  = (!r_m_valid || m_ready) && (!r_wb_valid || m_wb_ready);
    assign m_wb_valid = r_wb_valid;
    assign m_wb_age   = r_wb_age;
    assign m_wb_pixel = r_wb_pixel;
`else
    logic                w_unused_wb;
    logic [AGE_BITS-1:0] w_unused_aged;

    assign w_unused_wb   = m_wb_ready;
    assign w_unused_aged = w_aged;
    assign w_s_ready     = !r_m_valid || m_ready;
    assign m_wb_valid    = 1'b0;
    assign m_wb_age      = '0;
    assign m_wb_pixel    = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt <= '0;
            r_age_tick  <= 1'b0;
        end else if (w_accept && s_frame_end) begin
            if (fade_period == '0) begin
                r_frame_cnt <= '0;
                r_age_tick  <= 1'b0;
            end else if (w_frame_last) begin
                r_frame_cnt <= '0;
                r_age_tick  <= 1'b1;
            end else begin
                r_frame_cnt <= r_frame_cnt + PERIOD_WIDTH'(1);
                r_age_tick  <= 1'b0;
            end
        end
    end

    assign s_ready     = w_s_ready;
    assign m_valid     = r_m_valid;
    assign m_pixel     = r_pixel;
    assign m_frame_end = r_frame_end;
    assign age_tick    = r_age_tick;

endmodule
